iic_slave_responder: RTL
========================

Name: iic_slave_responder

Overview:
- Synthesizable IIC slave (responder) that answers the existing iic_drive master with EEPROM-style (AT24C64-like) transactions.
- Oversamples SCL/SDA on the system clock and decodes START, repeated START and STOP.
- Matches a fixed 7-bit device address, then receives a 1- or 2-byte word address.
- Writes or reads bytes through a simple synchronous memory port, auto-incrementing the pointer after each byte.
- Used as an RTL stand-in for the behavioural EEPROM model and as a slave endpoint in FPGA-to-FPGA links.

Parameters:
- P_DEVICE_ADDR, 7'b1010011, 7-bit slave address to match.
- P_ADDR_WIDTH, 16, word-address width received from the master; legal values 8 or 16 (1 or 2 address bytes).
- P_MEM_AW, 8, memory address width; the word pointer is taken modulo 2^P_MEM_AW.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-low reset.
- i_iic_scl  input  1  IIC clock from master; asynchronous.
- io_iic_sda  inout  1  IIC data, open-drain; driven 0 or high-Z only.
- o_mem_addr  output  P_MEM_AW  memory address for the current access.
- o_mem_wr_en  output  1  one-cycle write strobe.
- o_mem_wr_data  output  8  write data, valid with o_mem_wr_en.
- o_mem_rd_en  output  1  one-cycle read strobe.
- i_mem_rd_data  input  8  read data, valid exactly 1 cycle after o_mem_rd_en.
- o_busy  output  1  high from an address-matched START until STOP, NACK-end or mismatch.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All outputs go to 0; SDA is released (high-Z); state is IDLE; pointer is 0.
  - Reset mid-transfer aborts immediately. No memory strobe is issued in the cycle reset is low.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus one history FF.
  - Edges are detected on the synced signals.
- Bus conditions:
  - START: synced SDA 1->0 while synced SCL=1.
  - STOP: synced SDA 0->1 while synced SCL=1.
- Bit timing:
  - Data bits are sampled on the SCL rising edge.
  - SDA drive changes on the first i_clk after a detected SCL falling edge.
- State machine: IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ADDR_HI_ACK, ADDR_LO, ADDR_LO_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK, WAIT_STOP.
  - START from any state goes to DEV_ADDR and clears the bit counter; this covers repeated START. STOP from any state goes to IDLE, releases SDA and clears o_busy.
  - DEV_ADDR: shift 8 bits MSB first.
    - If [7:1]==P_DEVICE_ADDR, drive ACK (SDA=0) for the 9th clock and set o_busy.
    - On mismatch, do not drive and go to WAIT_STOP.
  - DEV_ADDR with R/W=0 leads to ADDR_HI (or ADDR_LO when P_ADDR_WIDTH=8). R/W=1 leads to RD_LOAD; the pointer is kept from the previous transaction.
  - Address bytes are ACKed. Pointer = received address[P_MEM_AW-1:0]; upper bits are ignored. After the last address byte, go to WR_DATA.
  - WR_DATA, after the 8th bit:
    - o_mem_wr_en pulses 1 cycle with o_mem_addr=pointer and the received byte.
    - Drive ACK; pointer increments, wrapping 2^P_MEM_AW-1 -> 0.
  - RD_LOAD:
    - o_mem_rd_en pulses with o_mem_addr=pointer.
    - i_mem_rd_data is latched into the shift register the next cycle, before the SCL falling edge that ends the ACK.
  - RD_DATA: drive the shift register MSB first; a 1 bit releases SDA.
  - After the 8th falling edge, release SDA and sample the master's bit in RD_MACK. Pointer increments (wrapping) after each byte sent.
    - ACK (0): go to RD_LOAD for the next byte.
    - NACK (1): go to WAIT_STOP.
  - ACK release: the slave releases SDA on the SCL falling edge that ends the 9th clock.
  - WAIT_STOP: SDA released; only START or STOP is acted on.
- Boundary cases:
  - STOP or START during a partial data byte: the byte is discarded and no write strobe is issued.
  - A write byte is committed only after all 8 bits are received.
  - o_mem_wr_en and o_mem_rd_en are never high in the same cycle.

Test Plan:
- Write: START, 0xA6, 0x00, 0x00, 0xAA, STOP -> four slave ACKs; exactly one o_mem_wr_en with addr 0x00 and data 0xAA; o_busy high throughout and low after STOP.
- Random read: mem[5]=0x3C. Send START, 0xA6, 0x00, 0x05, Sr, 0xA7, then read 1 byte with master NACK and STOP -> SDA carries 0x3C MSB first; one o_mem_rd_en with addr 0x05; no write strobe.
- Sequential read with wrap: pointer 0xFE, mem[FE..01]=11,22,33,44, read 4 bytes (ACK, ACK, ACK, NACK) -> bytes 11 22 33 44; rd addresses FE, FF, 00, 01.
- Address mismatch: START, 0xA0 -> SDA stays released on the 9th clock; no memory strobes; o_busy stays 0 until the next START.
- Aborted write: after the address bytes, send 5 data bits then STOP -> no o_mem_wr_en; state returns to IDLE; the next full write is ACKed normally.
- Reset mid-read: drive i_rst=0 while the slave drives SDA low -> SDA is high-Z on the next clock; all outputs 0; the following transaction works.

Source files
------------

// File: rtl/iic_slave_responder.sv
// IIC slave responder with EEPROM-style (AT24C64-like) framing.
// Bus lines are oversampled on i_clk. A matched device address is followed by
// one or two word-address bytes and then write data. A read continues from the
// current pointer. The pointer auto-increments and wraps modulo 2^P_MEM_AW.
module iic_slave_responder #(
    parameter logic [6:0] P_DEVICE_ADDR = 7'b1010011,
    parameter int         P_ADDR_WIDTH  = 16,
    parameter int         P_MEM_AW      = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_iic_scl,
    inout  wire                 io_iic_sda,
    output logic [P_MEM_AW-1:0] o_mem_addr,
    output logic                o_mem_wr_en,
    output logic [7:0]          o_mem_wr_data,
    output logic                o_mem_rd_en,
    input  logic [7:0]          i_mem_rd_data,
    output logic                o_busy
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DEV_ADDR    = 4'd1,
        DEV_ACK     = 4'd2,
        ADDR_HI     = 4'd3,
        ADDR_HI_ACK = 4'd4,
        ADDR_LO     = 4'd5,
        ADDR_LO_ACK = 4'd6,
        WR_DATA     = 4'd7,
        WR_ACK      = 4'd8,
        RD_LOAD     = 4'd9,
        RD_DATA     = 4'd10,
        RD_MACK     = 4'd11,
        WAIT_STOP   = 4'd12
    } state_t;

    // Pointer advance with natural wrap at 2^P_MEM_AW.
    function automatic logic [P_MEM_AW-1:0] ptr_inc(input logic [P_MEM_AW-1:0] p);
        return p + {{(P_MEM_AW-1){1'b0}}, 1'b1};
    endfunction

    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;
    logic rx_state_s, bit_in_s, byte_done_s;

    state_t              state_r, state_next_s;
    logic [3:0]          bit_cnt_r, bit_cnt_next_s;
    logic [7:0]          shift_r, shift_next_s;
    logic [P_MEM_AW-1:0] ptr_r, ptr_next_s;
    // rd_phase: 0 idle, 1 strobe issued, 2 data valid on the port, 3 loaded
    logic [1:0]          rd_phase_r, rd_phase_next_s;
    logic                sda_oe_r, sda_oe_next_s;
    logic                busy_r, busy_next_s;
    logic [P_MEM_AW-1:0] mem_addr_r, mem_addr_next_s;
    logic [7:0]          wr_data_r, wr_data_next_s;
    logic                wr_en_r, wr_en_next_s;
    logic                rd_en_r, rd_en_next_s;

    // Two-stage synchronizer plus one history stage for SCL and SDA; idle bus is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= i_iic_scl;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= io_iic_sda;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    assign scl_rise_s  = scl_sync_r & ~scl_hist_r;
    assign scl_fall_s  = ~scl_sync_r & scl_hist_r;
    assign start_s     = scl_sync_r & sda_hist_r & ~sda_sync_r;
    assign stop_s      = scl_sync_r & ~sda_hist_r & sda_sync_r;
    assign rx_state_s  = (state_r == DEV_ADDR) || (state_r == ADDR_HI) ||
                         (state_r == ADDR_LO) || (state_r == WR_DATA);
    assign bit_in_s    = scl_rise_s && (bit_cnt_r != 4'd8);
    assign byte_done_s = scl_fall_s && (bit_cnt_r == 4'd8);

    // Next-state, datapath and strobe decode; bus conditions take priority over every state.
    always_comb begin
        state_next_s    = state_r;
        bit_cnt_next_s  = bit_cnt_r;
        shift_next_s    = shift_r;
        ptr_next_s      = ptr_r;
        rd_phase_next_s = rd_phase_r;
        sda_oe_next_s   = sda_oe_r;
        busy_next_s     = busy_r;
        mem_addr_next_s = mem_addr_r;
        wr_data_next_s  = wr_data_r;
        wr_en_next_s    = 1'b0;
        rd_en_next_s    = 1'b0;

        if (stop_s) begin
            state_next_s    = IDLE;
            bit_cnt_next_s  = 4'd0;
            rd_phase_next_s = 2'd0;
            sda_oe_next_s   = 1'b0;
            busy_next_s     = 1'b0;
        end else if (start_s) begin
            state_next_s    = DEV_ADDR;
            bit_cnt_next_s  = 4'd0;
            rd_phase_next_s = 2'd0;
            sda_oe_next_s   = 1'b0;
        end else begin
            // Receiving states shift in one bit per SCL rise, MSB first.
            if (rx_state_s && bit_in_s) begin
                shift_next_s   = {shift_r[6:0], sda_sync_r};
                bit_cnt_next_s = bit_cnt_r + 4'd1;
            end else begin
                shift_next_s = shift_r;
            end

            case (state_r)
                DEV_ADDR: begin
                    if (byte_done_s) begin
                        bit_cnt_next_s = 4'd0;
                        if (shift_r[7:1] == P_DEVICE_ADDR) begin
                            sda_oe_next_s = 1'b1;
                            busy_next_s   = 1'b1;
                            if (shift_r[0]) begin
                                // Fetch during the ACK clock so bit 7 is ready at its falling edge.
                                state_next_s    = RD_LOAD;
                                rd_en_next_s    = 1'b1;
                                mem_addr_next_s = ptr_r;
                                rd_phase_next_s = 2'd1;
                            end else begin
                                state_next_s = DEV_ACK;
                            end
                        end else begin
                            busy_next_s  = 1'b0;
                            state_next_s = WAIT_STOP;
                        end
                    end else begin
                        state_next_s = DEV_ADDR;
                    end
                end
                DEV_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_next_s = 1'b0;
                        if (P_ADDR_WIDTH == 16) begin
                            state_next_s = ADDR_HI;
                        end else begin
                            state_next_s = ADDR_LO;
                        end
                    end else begin
                        state_next_s = DEV_ACK;
                    end
                end
                ADDR_HI: begin
                    if (byte_done_s) begin
                        bit_cnt_next_s = 4'd0;
                        sda_oe_next_s  = 1'b1;
                        ptr_next_s     = P_MEM_AW'({{P_MEM_AW{1'b0}}, shift_r});
                        state_next_s   = ADDR_HI_ACK;
                    end else begin
                        state_next_s = ADDR_HI;
                    end
                end
                ADDR_HI_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_next_s = 1'b0;
                        state_next_s  = ADDR_LO;
                    end else begin
                        state_next_s = ADDR_HI_ACK;
                    end
                end
                ADDR_LO: begin
                    if (byte_done_s) begin
                        bit_cnt_next_s = 4'd0;
                        sda_oe_next_s  = 1'b1;
                        state_next_s   = ADDR_LO_ACK;
                        // Upper word-address bits beyond P_MEM_AW fall off in the cast.
                        if (P_ADDR_WIDTH == 16) begin
                            ptr_next_s = P_MEM_AW'({ptr_r, shift_r});
                        end else begin
                            ptr_next_s = P_MEM_AW'({{P_MEM_AW{1'b0}}, shift_r});
                        end
                    end else begin
                        state_next_s = ADDR_LO;
                    end
                end
                ADDR_LO_ACK, WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_next_s = 1'b0;
                        state_next_s  = WR_DATA;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                WR_DATA: begin
                    if (byte_done_s) begin
                        bit_cnt_next_s  = 4'd0;
                        wr_en_next_s    = 1'b1;
                        mem_addr_next_s = ptr_r;
                        wr_data_next_s  = shift_r;
                        ptr_next_s      = ptr_inc(ptr_r);
                        sda_oe_next_s   = 1'b1;
                        state_next_s    = WR_ACK;
                    end else begin
                        state_next_s = WR_DATA;
                    end
                end
                RD_LOAD: begin
                    if (rd_phase_r == 2'd1) begin
                        rd_phase_next_s = 2'd2;
                    end else if (rd_phase_r == 2'd2) begin
                        shift_next_s    = i_mem_rd_data;
                        rd_phase_next_s = 2'd3;
                    end else if (scl_fall_s) begin
                        sda_oe_next_s   = ~shift_r[7];
                        bit_cnt_next_s  = 4'd0;
                        rd_phase_next_s = 2'd0;
                        state_next_s    = RD_DATA;
                    end else begin
                        state_next_s = RD_LOAD;
                    end
                end
                RD_DATA: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd7) begin
                            sda_oe_next_s  = 1'b0;
                            ptr_next_s     = ptr_inc(ptr_r);
                            bit_cnt_next_s = 4'd0;
                            state_next_s   = RD_MACK;
                        end else begin
                            shift_next_s   = {shift_r[6:0], 1'b0};
                            sda_oe_next_s  = ~shift_r[6];
                            bit_cnt_next_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_next_s = RD_DATA;
                    end
                end
                RD_MACK: begin
                    if (scl_rise_s) begin
                        if (!sda_sync_r) begin
                            state_next_s    = RD_LOAD;
                            rd_en_next_s    = 1'b1;
                            mem_addr_next_s = ptr_r;
                            rd_phase_next_s = 2'd1;
                        end else begin
                            busy_next_s  = 1'b0;
                            state_next_s = WAIT_STOP;
                        end
                    end else begin
                        state_next_s = RD_MACK;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_next_s = state_r;
                end
                default: begin
                    state_next_s  = IDLE;
                    sda_oe_next_s = 1'b0;
                    busy_next_s   = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered output update with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            ptr_r      <= {P_MEM_AW{1'b0}};
            rd_phase_r <= 2'd0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            mem_addr_r <= {P_MEM_AW{1'b0}};
            wr_data_r  <= 8'd0;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            ptr_r      <= ptr_next_s;
            rd_phase_r <= rd_phase_next_s;
            sda_oe_r   <= sda_oe_next_s;
            busy_r     <= busy_next_s;
            mem_addr_r <= mem_addr_next_s;
            wr_data_r  <= wr_data_next_s;
            wr_en_r    <= wr_en_next_s;
            rd_en_r    <= rd_en_next_s;
        end
    end

    assign io_iic_sda    = sda_oe_r ? 1'b0 : 1'bz;
    assign o_mem_addr    = mem_addr_r;
    assign o_mem_wr_en   = wr_en_r;
    assign o_mem_wr_data = wr_data_r;
    assign o_mem_rd_en   = rd_en_r;
    assign o_busy        = busy_r;

endmodule
